// File: rtl/sipo_pkg.sv
// Shared types and default sizing for the serial-to-parallel deserializer.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/sipo_out_fifo.sv
// Synchronous word FIFO with count-based full/empty; head word reads as zero when empty.
module sipo_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Collects framed serial bits into WIDTH-bit words and queues them for a ready/valid consumer.
//   state | meaning
//   IDLE  | waiting for a valid bit flagged with frame_start
//   SHIFT | word in progress, bit_count bits collected so far
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun,
  output logic                       frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             restart, take, push;
  logic [CW-1:0]    base_cnt, cnt_next;
  logic [WIDTH-1:0] word;
  int               pos;
  logic             fifo_empty, fifo_full;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take && !push) state_d = SHIFT;
      SHIFT:   if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    restart  = serial_valid && frame_start;
    take     = restart || (serial_valid && (state_q == SHIFT));
    // A frame_start bit always begins a fresh word, discarding any partial one.
    base_cnt = restart ? '0 : cnt_q;
    word     = restart ? '0 : shift_q;
    pos      = (MSB_FIRST != 0) ? (WIDTH - 1 - int'(base_cnt)) : int'(base_cnt);
    if (take) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == pos) word[i] = serial_in;
      end
    end
    cnt_next    = take ? (base_cnt + CW'(1)) : cnt_q;
    push        = take && (cnt_next == CW'(WIDTH));
    cnt_d       = push ? '0 : cnt_next;
    shift_d     = push ? '0 : word;
    frame_err_d = frame_err_q || (restart && (state_q == SHIFT));
    overrun_d   = overrun_q || (push && fifo_full && !out_ready);
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sipo_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock   (clock),
    .rstn    (rstn),
    .push    (push),
    .wr_data (word),
    .pop     (out_ready),
    .rd_data (parallel_out),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign bit_count = cnt_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scenario bench for sipo_deserializer against a queue-based reference model.
module tb_sipo_deserializer;

  localparam int W = 8;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         rstn = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic [3:0]   bit_count;
  logic         overrun;
  logic         frame_err;

  int n_vec = 0;
  int n_err = 0;

  int           m_bits[$];
  logic [W-1:0] m_fifo[$];
  bit           m_ovr;
  bit           m_ferr;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1), .FIFO_DEPTH(D)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bit_count    (bit_count),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clock = ~clock;

  // First received bit is the most significant.
  function automatic logic [W-1:0] compose();
    logic [W-1:0] w;
    w = '0;
    foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 unit after it.
  task automatic step(input logic sv, input logic si, input logic fs, input logic rdy);
    bit           pop, full, done;
    logic [W-1:0] w;
    serial_valid = sv;
    serial_in    = si;
    frame_start  = fs;
    out_ready    = rdy;
    done = 1'b0;
    w    = '0;
    if (!rstn) begin
      m_bits.delete();
      m_fifo.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      pop  = rdy && (m_fifo.size() > 0);
      full = (m_fifo.size() == D);
      if (sv && fs) begin
        if (m_bits.size() > 0) m_ferr = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(si));
      end else if (sv && m_bits.size() > 0) begin
        m_bits.push_back(int'(si));
      end
      if (m_bits.size() == W) begin
        w = compose();
        m_bits.delete();
        done = 1'b1;
      end
      if (pop) void'(m_fifo.pop_front());
      if (done) begin
        if (full && !pop) m_ovr = 1'b1;
        else m_fifo.push_back(w);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], (i == 0), (i == W-1) ? rdy_last : rdy_body);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({out_valid, parallel_out, bit_count, overrun, frame_err} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h cnt=%0d ovr=%b ferr=%b, need all zero",
               out_valid, parallel_out, bit_count, overrun, frame_err);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    do_reset();
    w = 8'hB8;
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], (i == 0), 1'b0);
      if (i == W-2) begin
        n_vec++;
        if (out_valid !== 1'b0 || bit_count !== 4'd7) begin
          n_err++;
          $display("FAIL basic_pre_last: got v=%b cnt=%0d, need v=0 cnt=7", out_valid, bit_count);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || parallel_out !== 8'hB8 || bit_count !== 4'd0) begin
      n_err++;
      $display("FAIL basic_word: got v=%b d=%h cnt=%0d, need v=1 d=b8 cnt=0",
               out_valid, parallel_out, bit_count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pop: got v=%b, need 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] w;
    do_reset();
    w = 8'hB8;
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], (i == 0), 1'b0);
      if (i < W-1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        n_vec++;
        if (bit_count !== 4'(i + 1)) begin
          n_err++;
          $display("FAIL gaps_hold: got cnt=%0d, need %0d", bit_count, i + 1);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || parallel_out !== 8'hB8) begin
      n_err++;
      $display("FAIL gaps_word: got v=%b d=%h, need v=1 d=b8", out_valid, parallel_out);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send_word(8'h7D, 1'b0, 1'b0);
    n_vec++;
    if (frame_err !== 1'b1 || out_valid !== 1'b1 || parallel_out !== 8'h7D) begin
      n_err++;
      $display("FAIL frame_err_word: got ferr=%b v=%b d=%h, need ferr=1 v=1 d=7d",
               frame_err, out_valid, parallel_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL frame_err_single: got v=%b ferr=%b, need v=0 ferr=1", out_valid, frame_err);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'h60, 1'b0, 1'b0);
    send_word(8'hD8, 1'b0, 1'b0);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_early: got ovr=%b, need 0", overrun);
    end
    send_word(8'hDD, 1'b0, 1'b0);
    n_vec++;
    if (overrun !== 1'b1 || parallel_out !== 8'h60) begin
      n_err++;
      $display("FAIL overrun_set: got ovr=%b d=%h, need ovr=1 d=60", overrun, parallel_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || parallel_out !== 8'hD8) begin
      n_err++;
      $display("FAIL overrun_second: got v=%b d=%h, need v=1 d=d8", out_valid, parallel_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_drained: got v=%b ovr=%b, need v=0 ovr=1", out_valid, overrun);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send_word(8'h60, 1'b0, 1'b0);
    send_word(8'hD8, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b1);
    n_vec++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || parallel_out !== 8'hD8) begin
      n_err++;
      $display("FAIL fullpp_head: got ovr=%b v=%b d=%h, need ovr=0 v=1 d=d8",
               overrun, out_valid, parallel_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || parallel_out !== 8'h11) begin
      n_err++;
      $display("FAIL fullpp_tail: got v=%b d=%h, need v=1 d=11", out_valid, parallel_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fullpp_empty: got v=%b, need 0", out_valid);
    end
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] w;
    do_reset();
    send_word(8'h60, 1'b0, 1'b0);
    w = 8'hB8;
    for (int i = 0; i < 5; i++) step(1'b1, w[W-1-i], (i == 0), 1'b0);
    n_vec++;
    if (bit_count !== 4'd5) begin
      n_err++;
      $display("FAIL midword_count: got cnt=%0d, need 5", bit_count);
    end
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rstn = 1'b1;
    n_vec++;
    if ({out_valid, parallel_out, bit_count, overrun, frame_err} !== 15'h0) begin
      n_err++;
      $display("FAIL midword_reset: got v=%b d=%h cnt=%0d ovr=%b ferr=%b, need all zero",
               out_valid, parallel_out, bit_count, overrun, frame_err);
    end
    send_word(8'hB8, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || parallel_out !== 8'hB8 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL midword_next: got v=%b d=%h ferr=%b, need v=1 d=b8 ferr=0",
               out_valid, parallel_out, frame_err);
    end
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rstn = ($urandom_range(0, 149) != 0);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 13) == 0), 1'($urandom_range(0, 1)));
      exp = {(m_fifo.size() > 0), (m_fifo.size() > 0) ? m_fifo[0] : 8'h00,
             4'(m_bits.size()), m_ovr, m_ferr};
      got = {out_valid, parallel_out, bit_count, overrun, frame_err};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random cycle %0d: got {v,d,cnt,ovr,ferr}=%h, need %h", c, got, exp);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_frame_err();
    test_overrun();
    test_full_push_pop();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
